// File: rtl/rv_branch_pkg.sv
// rv_branch_pkg: branch condition codes, resolver FSM states and PC increment.
package rv_branch_pkg;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  localparam logic [31:0] PC_INC = 32'd4;
  typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;
endpackage

// File: rtl/branch_compare.sv
// branch_compare: conditional-branch direction from operands and func3.
module branch_compare
  import rv_branch_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  func3,
  output logic        taken
);
  assign taken = func3 == F3_BEQ  ? a == b :
                 func3 == F3_BNE  ? a != b :
                 func3 == F3_BLT  ? $signed(a) <  $signed(b) :
                 func3 == F3_BGE  ? $signed(a) >= $signed(b) :
                 func3 == F3_BLTU ? a <  b :
                 func3 == F3_BGEU ? a >= b : 1'b0;
endmodule

// File: rtl/ex_branch_resolver.sv
// ex_branch_resolver: resolves EX control flow against the IF prediction, drives redirect/flush/predictor update.
module ex_branch_resolver
  import rv_branch_pkg::*;
#(
  parameter int GHR_W        = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_EX_in,
  input  logic             stall_EX_in,
  input  logic             branch_EX_in,
  input  logic             is_jal_EX_in,
  input  logic             is_jalr_EX_in,
  input  logic [2:0]       func3_EX_in,
  input  logic [31:0]      rs1_val_EX_in,
  input  logic [31:0]      rs2_val_EX_in,
  input  logic [31:0]      imm_EX_in,
  input  logic [31:0]      pc_EX_in,
  input  logic [31:0]      predicted_pc_EX_in,
  input  logic             prediction_valid_EX_in,
  input  logic [GHR_W-1:0] ghr_EX_in,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             flush_IF_ID,
  output logic             flush_ID_EX,
  output logic             upd_valid,
  output logic [31:0]      upd_pc,
  output logic             upd_taken,
  output logic [31:0]      upd_target,
  output logic             upd_invalidate,
  output logic             ghr_restore_valid,
  output logic [GHR_W-1:0] ghr_restore_value,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);
  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic        cond, resolve, is_ctrl, taken, mis, upd, ctrl_mis;
  logic [31:0] pc_seq, target, actual_next, pred_next;
  branch_compare u_cmp (
    .a     (rs1_val_EX_in),
    .b     (rs2_val_EX_in),
    .func3 (func3_EX_in),
    .taken (cond)
  );
  assign resolve     = valid_EX_in & ~stall_EX_in & (state == IDLE);
  assign is_ctrl     = branch_EX_in | is_jal_EX_in | is_jalr_EX_in;
  assign taken       = is_jal_EX_in | is_jalr_EX_in | (branch_EX_in & cond);
  assign pc_seq      = pc_EX_in + PC_INC;
  assign target      = is_jalr_EX_in ? (rs1_val_EX_in + imm_EX_in) & ~32'h1 : pc_EX_in + imm_EX_in;
  assign actual_next = taken ? target : pc_seq;
  assign pred_next   = prediction_valid_EX_in ? predicted_pc_EX_in : pc_seq;
  // A non-control instruction that hit in the BTB always needs a redirect and an invalidate.
  assign mis         = resolve & (is_ctrl ? actual_next != pred_next : prediction_valid_EX_in);
  assign upd         = resolve & (is_ctrl | prediction_valid_EX_in);
  assign ctrl_mis    = mis & is_ctrl;
  assign flush_IF_ID = state == FLUSH;
  assign flush_ID_EX = state == FLUSH;
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (state == IDLE) begin
      state_n = mis ? FLUSH : IDLE;
      cnt_n   = mis ? 4'(FLUSH_CYCLES - 1) : cnt;
    end else begin
      state_n = cnt == 4'd0 ? IDLE : FLUSH;
      cnt_n   = cnt == 4'd0 ? cnt : cnt - 4'd1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      cnt               <= '0;
      redirect_valid    <= 1'b0;
      redirect_pc       <= '0;
      upd_valid         <= 1'b0;
      upd_pc            <= '0;
      upd_taken         <= 1'b0;
      upd_target        <= '0;
      upd_invalidate    <= 1'b0;
      ghr_restore_valid <= 1'b0;
      ghr_restore_value <= '0;
      branch_count      <= '0;
      mispredict_count  <= '0;
    end else begin
      state             <= state_n;
      cnt               <= cnt_n;
      redirect_valid    <= mis;
      redirect_pc       <= mis ? actual_next : '0;
      upd_valid         <= upd;
      upd_pc            <= upd ? pc_EX_in : '0;
      upd_taken         <= upd & taken;
      upd_target        <= upd ? actual_next : '0;
      upd_invalidate    <= resolve & ~is_ctrl & prediction_valid_EX_in;
      ghr_restore_valid <= ctrl_mis;
      ghr_restore_value <= !ctrl_mis ? '0 : branch_EX_in ? {ghr_EX_in[GHR_W-2:0], taken} : ghr_EX_in;
      if (resolve & is_ctrl & ~&branch_count)
        branch_count <= branch_count + 1'b1;
      if (mis & ~&mispredict_count)
        mispredict_count <= mispredict_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_ex_branch_resolver.sv
// tb_ex_branch_resolver: directed + random stimulus, scoreboard of expected update/redirect events.
module tb_ex_branch_resolver;
  localparam int FC = 2;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;
  typedef struct packed {
    logic        redir;
    logic [31:0] rpc;
    logic        upd;
    logic [31:0] upc;
    logic        utk;
    logic [31:0] utgt;
    logic        uinv;
    logic        grv;
    logic [3:0]  grval;
  } ev_t;
  logic clk = 1'b0, rst = 1'b1;
  logic valid, stall, br, jal, jalr, pv;
  logic [2:0] f3;
  logic [31:0] rs1, rs2, imm, pc, pp;
  logic [3:0] ghr;
  logic redirect_valid, flush_IF_ID, flush_ID_EX, upd_valid, upd_taken, upd_invalidate, ghr_restore_valid;
  logic [31:0] redirect_pc, upd_pc, upd_target;
  logic [3:0] ghr_restore_value;
  logic [CW-1:0] branch_count, mispredict_count;
  ev_t q[$];
  int tests = 0, fails = 0;
  int fl = 0, ebc = 0, emc = 0;
  bit mon_en = 1'b0;

  ex_branch_resolver #(.GHR_W(4), .FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .valid_EX_in(valid), .stall_EX_in(stall), .branch_EX_in(br),
    .is_jal_EX_in(jal), .is_jalr_EX_in(jalr), .func3_EX_in(f3), .rs1_val_EX_in(rs1),
    .rs2_val_EX_in(rs2), .imm_EX_in(imm), .pc_EX_in(pc), .predicted_pc_EX_in(pp),
    .prediction_valid_EX_in(pv), .ghr_EX_in(ghr), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .flush_IF_ID(flush_IF_ID), .flush_ID_EX(flush_ID_EX),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_invalidate(upd_invalidate), .ghr_restore_valid(ghr_restore_valid),
    .ghr_restore_value(ghr_restore_value), .branch_count(branch_count),
    .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  function automatic logic cond_of(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // Reference model for the instruction currently on the inputs; advances flush and counter state.
  task automatic issue();
    ev_t e;
    logic res, ctrl, tk, mis;
    logic [31:0] nxt, pn;
    res  = valid && !stall && fl == 0;
    ctrl = br | jal | jalr;
    tk   = jal | jalr | (br & cond_of(f3, rs1, rs2));
    nxt  = !tk ? pc + 32'd4 : jalr ? ((rs1 + imm) & 32'hFFFF_FFFE) : pc + imm;
    pn   = pv ? pp : pc + 32'd4;
    mis  = ctrl ? nxt != pn : pv;
    if (res) begin
      if (ctrl || pv) begin
        e = '0;
        e.redir = mis;
        e.rpc   = mis ? nxt : 32'd0;
        e.upd   = 1'b1;
        e.upc   = pc;
        e.utk   = tk;
        e.utgt  = nxt;
        e.uinv  = !ctrl;
        e.grv   = mis && ctrl;
        e.grval = !(mis && ctrl) ? 4'd0 : br ? {ghr[2:0], tk} : ghr;
        q.push_back(e);
      end
      if (ctrl) ebc = ebc < CMAX ? ebc + 1 : CMAX;
      if (mis) emc = emc < CMAX ? emc + 1 : CMAX;
    end
    fl = (res && mis) ? FC : (fl > 0 ? fl - 1 : 0);
  endtask

  task automatic set_in(input logic v, input logic s, input logic b, input logic j, input logic jr,
                        input logic [2:0] c, input logic [31:0] a, input logic [31:0] bb,
                        input logic [31:0] im, input logic [31:0] p, input logic pvi,
                        input logic [31:0] ppi, input logic [3:0] g);
    valid = v; stall = s; br = b; jal = j; jalr = jr; f3 = c;
    rs1 = a; rs2 = bb; imm = im; pc = p; pv = pvi; pp = ppi; ghr = g;
  endtask

  task automatic step();
    issue();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      set_in(0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 4'd0);
      step();
    end
  endtask

  initial begin
    ev_t a;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        chk("flush_IF_ID", flush_IF_ID, fl > 0);
        chk("flush_ID_EX", flush_ID_EX, fl > 0);
        chk("branch_count", branch_count, ebc);
        chk("mispredict_count", mispredict_count, emc);
        if (upd_valid || redirect_valid || ghr_restore_valid) begin
          a = '{redirect_valid, redirect_pc, upd_valid, upd_pc, upd_taken, upd_target,
                upd_invalidate, ghr_restore_valid, ghr_restore_value};
          if (q.size() == 0) chk("unexpected_event", a, 0);
          else begin
            tests++;
            if (a !== q[0]) begin
              fails++;
              $display("FAIL event: got %h expected %h", a, q[0]);
            end
            void'(q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] r;
    int kind;
    set_in(0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 4'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_upd_valid", upd_valid, 0);
    chk("reset_redirect_pc", redirect_pc, 0);
    chk("reset_flush", flush_IF_ID, 0);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;
    // Correctly predicted taken BEQ
    set_in(1, 0, 1, 0, 0, 3'd0, 5, 5, 32'h20, 32'h100, 1, 32'h120, 4'd0);
    step();
    chk("t1_upd_taken", upd_taken, 1);
    chk("t1_redirect", redirect_valid, 0);
    chk("t1_branch_count", branch_count, 1);
    idle(1);
    // BNE predicted taken but falls through
    set_in(1, 0, 1, 0, 0, 3'd1, 7, 7, 32'h40, 32'h200, 1, 32'h240, 4'b1011);
    step();
    chk("t2_redirect_pc", redirect_pc, 32'h204);
    chk("t2_ghr_value", ghr_restore_value, 4'b0110);
    chk("t2_mispredict_count", mispredict_count, 1);
    idle(2);
    set_in(1, 0, 0, 0, 1, 3'd0, 32'h1001, 0, 32'h4, 32'h300, 0, 0, 4'd3);
    step();
    chk("t3_redirect_pc", redirect_pc, 32'h1004);
    chk("t3_upd_target", upd_target, 32'h1004);
    idle(2);
    set_in(1, 0, 1, 0, 0, 3'd4, 32'hFFFF_FFFF, 1, 32'h10, 32'h400, 1, 32'h410, 4'd0);
    step();
    chk("t4_blt_taken", upd_taken, 1);
    set_in(1, 0, 1, 0, 0, 3'd6, 32'hFFFF_FFFF, 1, 32'h10, 32'h404, 0, 0, 4'd0);
    step();
    chk("t4_bltu_taken", upd_taken, 0);
    idle(1);
    // JAL mispredict followed by a wrong-path BEQ, then reset inside the flush burst
    set_in(1, 0, 0, 1, 0, 3'd0, 0, 0, 32'h40, 32'h500, 0, 0, 4'd5);
    step();
    set_in(1, 0, 1, 0, 0, 3'd0, 1, 1, 32'h8, 32'h504, 0, 0, 4'd5);
    step();
    chk("t5_wrong_path_upd", upd_valid, 0);
    chk("t5_flush_still_high", flush_IF_ID, 1);
    set_in(0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 4'd0);
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("t5_rst_flush_IF_ID", flush_IF_ID, 0);
    chk("t5_rst_flush_ID_EX", flush_ID_EX, 0);
    chk("t5_rst_branch_count", branch_count, 0);
    chk("t5_rst_mispredict_count", mispredict_count, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    q.delete();
    fl = 0; ebc = 0; emc = 0;
    mon_en = 1'b1;
    set_in(1, 0, 0, 0, 0, 3'd0, 0, 0, 0, 32'h40, 1, 32'h80, 4'd0);
    step();
    chk("t6_redirect_pc", redirect_pc, 32'h44);
    chk("t6_upd_invalidate", upd_invalidate, 1);
    idle(2);
    for (int i = 0; i < 3; i++) begin
      set_in(1, 1, 1, 0, 0, 3'd1, 3, 3, 32'h40, 32'h600, 1, 32'h640, 4'd0);
      step();
      chk("t6_stall_upd", upd_valid, 0);
      chk("t6_stall_redirect", redirect_valid, 0);
    end
    set_in(1, 0, 1, 0, 0, 3'd1, 3, 3, 32'h40, 32'h600, 1, 32'h640, 4'd0);
    step();
    chk("t6_release_redirect", redirect_pc, 32'h604);
    idle(2);
    for (int i = 0; i < 400; i++) begin
      kind = $urandom_range(0, 4);
      r = $urandom;
      valid = $urandom_range(0, 7) != 0;
      stall = $urandom_range(0, 5) == 0;
      br = kind == 1 || kind == 2;
      jal = kind == 3;
      jalr = kind == 4;
      f3 = 3'($urandom_range(0, 7));
      rs1 = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 3)) - 32'd1;
      rs2 = $urandom_range(0, 1) ? rs1 : 32'($urandom_range(0, 3)) - 32'd1;
      imm = {{20{r[11]}}, r[11:1], 1'b0};
      pc = $urandom & 32'hFFFF_FFFC;
      pv = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0: pp = pc + imm;
        1: pp = pc + 32'd4;
        default: pp = $urandom;
      endcase
      ghr = 4'($urandom);
      step();
    end
    idle(4);
    chk("scoreboard_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
